// File: rtl/sparc_muldiv_unit.sv
// Iterative SPARC multiply/divide unit: one bit per cycle, magnitude datapath, sign fix at the end.
// state  | meaning
// IDLE   | waiting for req; outputs hold last completed result
// CALC   | first cycle forms magnitudes (or traps on /0), then WIDTH shift-add/sub steps
// FINISH | sign correction, saturation and flag update (only when SIGN_FIX_CYCLE=1)
module sparc_muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int SIGN_FIX_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [WIDTH-1:0] y_in,
  output logic             reqack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] y_out,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C,
  output logic             trap
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]    PREP   = CW'(WIDTH + 1);
  localparam logic [CW-1:0]    LAST   = CW'(1);
  localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [W2-1:0]    p_q, p_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sa_q, sa_d, sp_q, sp_d, ovf_hi_q, ovf_hi_d;
  logic             reqack_q, reqack_d, busy_q, busy_d, done_q, done_d, trap_q, trap_d;
  logic [WIDTH-1:0] result_q, result_d, y_out_q, y_out_d;
  logic             n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d;

  logic [WIDTH-1:0] mag_a;
  logic [W2-1:0]    mag_p;
  logic [WIDTH:0]   mul_sum, div_tmp;
  logic [WIDTH-1:0] div_rem;
  logic             div_ge, neg_res, fin_ovf, finish;
  logic [W2-1:0]    p_step, fin_src, prod_fix;
  logic [WIDTH-1:0] q_mag, fin_result, fin_yout;

  // a_q: multiplicand or divisor; p_q: {acc, multiplier} or {remainder, quotient}
  always_comb begin
    mag_a   = sa_q ? -a_q : a_q;
    mag_p   = mode_q[2] ? (sp_q ? -p_q : p_q)
                        : {{WIDTH{1'b0}}, (sp_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0])};
    mul_sum = {1'b0, p_q[W2-1:WIDTH]} + {1'b0, (a_q & {WIDTH{p_q[0]}})};
    div_tmp = {p_q[W2-1:WIDTH], p_q[WIDTH-1]};
    div_ge  = div_tmp >= {1'b0, a_q};
    div_rem = div_ge ? (div_tmp[WIDTH-1:0] - a_q) : div_tmp[WIDTH-1:0];
    p_step  = mode_q[2] ? {div_rem, p_q[WIDTH-2:0], div_ge} : {mul_sum, p_q[WIDTH-1:1]};
    fin_src = (state_q == S_FINISH) ? p_q : p_step;
    neg_res = sa_q ^ sp_q;
    prod_fix = neg_res ? -fin_src : fin_src;
    q_mag   = fin_src[WIDTH-1:0];

    fin_ovf    = 1'b0;
    fin_result = prod_fix[WIDTH-1:0];
    fin_yout   = prod_fix[W2-1:WIDTH];
    if (mode_q[2]) begin
      fin_yout = y_q;
      if (!mode_q[1]) begin
        fin_ovf    = ovf_hi_q;
        fin_result = ovf_hi_q ? '1 : q_mag;
      end else if (neg_res) begin
        fin_ovf    = ovf_hi_q || (q_mag > MINNEG);
        fin_result = fin_ovf ? MINNEG : -q_mag;
      end else begin
        fin_ovf    = ovf_hi_q || q_mag[WIDTH-1];
        fin_result = fin_ovf ? MAXPOS : q_mag;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    a_d      = a_q;
    p_d      = p_q;
    y_d      = y_q;
    sa_d     = sa_q;
    sp_d     = sp_q;
    ovf_hi_d = ovf_hi_q;
    reqack_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    trap_d   = trap_q;
    result_d = result_q;
    y_out_d  = y_out_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
    c_d      = c_q;
    finish   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_CALC;
          cnt_d    = PREP;
          mode_d   = mode;
          a_d      = mode[2] ? operand2 : operand1;
          p_d      = mode[2] ? {y_in, operand1} : {{WIDTH{1'b0}}, operand2};
          y_d      = y_in;
          sa_d     = mode[1] & (mode[2] ? operand2[WIDTH-1] : operand1[WIDTH-1]);
          sp_d     = mode[1] & (mode[2] ? y_in[WIDTH-1] : operand2[WIDTH-1]);
          reqack_d = 1'b1;
          busy_d   = 1'b1;
          trap_d   = 1'b0;
        end
      end
      S_CALC: begin
        if (cnt_q == PREP) begin
          if (mode_q[2] && (a_q == '0)) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            trap_d   = 1'b1;
            result_d = '0;
          end else begin
            a_d      = mag_a;
            p_d      = mag_p;
            // high dividend half >= divisor means the quotient cannot fit in WIDTH bits
            ovf_hi_d = mag_p[W2-1:WIDTH] >= mag_a;
            cnt_d    = cnt_q - LAST;
          end
        end else begin
          p_d   = p_step;
          cnt_d = cnt_q - LAST;
          if (cnt_q == LAST) begin
            if (SIGN_FIX_CYCLE != 0) state_d = S_FINISH;
            else                     finish  = 1'b1;
          end
        end
      end
      S_FINISH: finish = 1'b1;
      default:  state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      result_d = fin_result;
      y_out_d  = fin_yout;
      if (mode_q[0]) begin
        n_d = fin_result[WIDTH-1];
        z_d = (fin_result == '0);
        v_d = mode_q[2] & fin_ovf;
        c_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= '0;
      a_q      <= '0;
      p_q      <= '0;
      y_q      <= '0;
      sa_q     <= 1'b0;
      sp_q     <= 1'b0;
      ovf_hi_q <= 1'b0;
      reqack_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      trap_q   <= 1'b0;
      result_q <= '0;
      y_out_q  <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      p_q      <= p_d;
      y_q      <= y_d;
      sa_q     <= sa_d;
      sp_q     <= sp_d;
      ovf_hi_q <= ovf_hi_d;
      reqack_q <= reqack_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      trap_q   <= trap_d;
      result_q <= result_d;
      y_out_q  <= y_out_d;
      n_q      <= n_d;
      z_q      <= z_d;
      v_q      <= v_d;
      c_q      <= c_d;
    end
  end

  assign reqack = reqack_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign trap   = trap_q;
  assign result = result_q;
  assign y_out  = y_out_q;
  assign N      = n_q;
  assign Z      = z_q;
  assign V      = v_q;
  assign C      = c_q;

endmodule
